// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter
// Shares one six-digit display path between three content sources:
// source 0 = alarm (pre-emptive), source 1 = live temperature and
// source 2 = setpoint (round-robin with a fixed dwell time).
// Every change of owner inserts a blanking gap so stale digits never flash.
//
// Optional feature macro: SEG_BLINK_EN. When defined, the display blinks
// while the alarm source owns it.
//
// Parameters:
//   DWELL_CNT  cycles a source 1/2 owner keeps the display before rotating (>=2)
//   GAP_CNT    blanking cycles between owners (>=1)
//   BLINK_CNT  alarm blink half-period in cycles (SEG_BLINK_EN only)
// Ports:
//   sys_clk                    clock
//   sys_rst                    synchronous reset, active-high
//   req[2:0]                   level request per source
//   data_0/1/2 [19:0]          display value per source
//   point_0/1/2 [5:0]          decimal-point mask per source
//   sign_in[2:0]               negative flag per source
//   grant[2:0]                 one-hot owner, 0 when idle or blanking
//   data/point/sign            registered display payload
//   seg_en                     registered display enable
module seg_disp_arbiter #(
  parameter int unsigned DWELL_CNT = 25_000_000,
  parameter int unsigned GAP_CNT   = 500_000,
  parameter int unsigned BLINK_CNT = 12_500_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [2:0]  req,
  input  logic [19:0] data_0,
  input  logic [19:0] data_1,
  input  logic [19:0] data_2,
  input  logic [5:0]  point_0,
  input  logic [5:0]  point_1,
  input  logic [5:0]  point_2,
  input  logic [2:0]  sign_in,
  output logic [2:0]  grant,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        seg_en
);

  localparam int unsigned DWELL_W = (DWELL_CNT > 1) ? $clog2(DWELL_CNT) : 1;
  localparam int unsigned GAP_W   = (GAP_CNT > 1) ? $clog2(GAP_CNT) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CNT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CNT - 1);

  // Out-of-range parameters leave this marker scope in the elaborated design.
  if (DWELL_CNT < 2 || GAP_CNT < 1 || BLINK_CNT < 1) begin : g_param_range_violation
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         owner;
  logic [1:0]         last_rr;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [GAP_W-1:0]   gap_cnt;

`ifdef SEG_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CNT - 1);
  logic [BLINK_W-1:0] blink_cnt;
`endif

  // Priority winner, owner-side payload mux and exit conditions
  logic        win_valid_c;
  logic [1:0]  win_idx_c;
  logic [19:0] win_data_c, own_data_c;
  logic [5:0]  win_point_c, own_point_c;
  logic        win_sign_c, own_sign_c;
  logic        other_req_c;
  logic        leave_c;
  logic        take_c;

  always_comb begin
    win_valid_c = 1'b0;
    win_idx_c   = 2'd0;
    if (req[0]) begin
      win_valid_c = 1'b1;
      win_idx_c   = 2'd0;
    end else if (req[1] && req[2]) begin
      // Tie between rotation sources: the one not served last wins
      win_valid_c = 1'b1;
      win_idx_c   = (last_rr == 2'd1) ? 2'd2 : 2'd1;
    end else if (req[1]) begin
      win_valid_c = 1'b1;
      win_idx_c   = 2'd1;
    end else if (req[2]) begin
      win_valid_c = 1'b1;
      win_idx_c   = 2'd2;
    end

    case (win_idx_c)
      2'd1:    begin win_data_c = data_1; win_point_c = point_1; win_sign_c = sign_in[1]; end
      2'd2:    begin win_data_c = data_2; win_point_c = point_2; win_sign_c = sign_in[2]; end
      default: begin win_data_c = data_0; win_point_c = point_0; win_sign_c = sign_in[0]; end
    endcase

    case (owner)
      2'd1:    begin own_data_c = data_1; own_point_c = point_1; own_sign_c = sign_in[1]; end
      2'd2:    begin own_data_c = data_2; own_point_c = point_2; own_sign_c = sign_in[2]; end
      default: begin own_data_c = data_0; own_point_c = point_0; own_sign_c = sign_in[0]; end
    endcase

    other_req_c = (owner == 2'd1) ? req[2] : req[1];

    // Drop, alarm pre-emption or dwell expiry all collapse into one BLANK
    leave_c = !req[owner]
            || ((owner != 2'd0) && req[0])
            || ((owner != 2'd0) && other_req_c && (dwell_cnt == DWELL_LAST));

    take_c = win_valid_c
          && ((state == ST_IDLE) || ((state == ST_BLANK) && (gap_cnt == GAP_LAST)));
  end

  // State, counters and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      owner     <= 2'd0;
      last_rr   <= 2'd2;
      dwell_cnt <= '0;
      gap_cnt   <= '0;
      grant     <= '0;
      data      <= '0;
      point     <= '0;
      sign      <= 1'b0;
      seg_en    <= 1'b0;
`ifdef SEG_BLINK_EN
      blink_cnt <= '0;
`endif
    end else if (take_c) begin
      state     <= ST_SHOW;
      owner     <= win_idx_c;
      grant     <= 3'b001 << win_idx_c;
      data      <= win_data_c;
      point     <= win_point_c;
      sign      <= win_sign_c;
      seg_en    <= 1'b1;
      dwell_cnt <= '0;
      if (win_idx_c != 2'd0) last_rr <= win_idx_c;
`ifdef SEG_BLINK_EN
      blink_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_SHOW: begin
          if (leave_c) begin
            state   <= ST_BLANK;
            gap_cnt <= '0;
            grant   <= '0;
            seg_en  <= 1'b0;
          end else begin
            data  <= own_data_c;
            point <= own_point_c;
            sign  <= own_sign_c;
            // Dwell only accumulates while the rotation partner is waiting
            if ((owner != 2'd0) && other_req_c && (dwell_cnt != DWELL_LAST))
              dwell_cnt <= dwell_cnt + DWELL_W'(1);
`ifdef SEG_BLINK_EN
            if (owner == 2'd0) begin
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                seg_en    <= !seg_en;
              end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
              end
            end
`endif
          end
        end
        ST_BLANK: begin
          // Gap end with a winner is handled by take_c
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else                     gap_cnt <= gap_cnt + GAP_W'(1);
        end
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter with DWELL_CNT=8, GAP_CNT=2, BLINK_CNT=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_disp_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  req;
  logic [19:0] data_0, data_1, data_2;
  logic [5:0]  point_0, point_1, point_2;
  logic [2:0]  sign_in;
  logic [2:0]  grant;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  seg_disp_arbiter #(
    .DWELL_CNT(8),
    .GAP_CNT  (2),
    .BLINK_CNT(4)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .req    (req),
    .data_0 (data_0),
    .data_1 (data_1),
    .data_2 (data_2),
    .point_0(point_0),
    .point_1(point_1),
    .point_2(point_2),
    .sign_in(sign_in),
    .grant  (grant),
    .data   (data),
    .point  (point),
    .sign   (sign),
    .seg_en (seg_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
  endtask

  initial begin
    logic [2:0] exp_g;
    logic       exp_en;

    sys_rst = 1'b1;
    req     = 3'b111;
    data_0  = 20'h12345; point_0 = 6'b000100;
    data_1  = 20'h00001; point_1 = 6'b000010;
    data_2  = 20'h00250; point_2 = 6'b000001;
    sign_in = 3'b100;

    // Reset with every request held
    repeat (3) step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_point", 32'(point), 32'h0);
    check("rst_sign", 32'(sign), 32'h0);
    check("rst_seg_en", 32'(seg_en), 32'h0);

    // Alarm wins the first edge after release
    sys_rst = 1'b0;
    step();
    check("alarm_grant", 32'(grant), 32'h1);
    check("alarm_data", 32'(data), 32'h12345);
    check("alarm_point", 32'(point), 32'h04);
    check("alarm_sign", 32'(sign), 32'h0);

    // Alarm hold: blink pattern or steady enable
    for (int i = 0; i < 9; i++) begin
`ifdef SEG_BLINK_EN
      exp_en = (i < 4) || (i >= 8);
`else
      exp_en = 1'b1;
`endif
      check($sformatf("alarm_seg_en_%0d", i), 32'(seg_en), 32'(exp_en));
      check($sformatf("alarm_hold_%0d", i), 32'(grant), 32'h1);
      step();
    end

    // Release everything: gap then idle, payload held
    req = 3'b000;
    step();
    check("drop_data_hold", 32'(data), 32'h12345);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("idle_grant_%0d", j), 32'(grant), 32'h0);
      check($sformatf("idle_seg_en_%0d", j), 32'(seg_en), 32'h0);
      step();
    end

    // Temperature and setpoint both request: source 1 first (last_rr=2)
    req    = 3'b110;
    data_1 = 20'h00253;
    step();
    for (int i = 0; i <= 20; i++) begin
      if (i < 8)       exp_g = 3'b010;
      else if (i < 10) exp_g = 3'b000;
      else if (i < 18) exp_g = 3'b100;
      else if (i < 20) exp_g = 3'b000;
      else             exp_g = 3'b010;
      check($sformatf("rot_grant_%0d", i), 32'(grant), 32'(exp_g));
      check($sformatf("rot_seg_en_%0d", i), 32'(seg_en), 32'(exp_g != 3'b000));
      if (i == 0) begin
        check("temp_data", 32'(data), 32'h00253);
        data_1 = 20'h00777;
      end
      if (i == 1) check("temp_data_follow", 32'(data), 32'h00777);
      if (i == 8) check("gap_data_hold", 32'(data), 32'h00777);
      if (i == 10) begin
        check("set_data", 32'(data), 32'h00250);
        check("set_point", 32'(point), 32'h01);
        check("set_sign", 32'(sign), 32'h1);
      end
      if (i < 20) step();
    end

    // Pre-empt owner 1 at dwell cycle 3
    repeat (3) step();
    check("pre_owner1", 32'(grant), 32'h2);
    req = 3'b111;
    step();
    check("pre_gap0", 32'(grant), 32'h0);
    check("pre_gap0_en", 32'(seg_en), 32'h0);
    step();
    check("pre_gap1", 32'(grant), 32'h0);
    step();
    check("pre_alarm", 32'(grant), 32'h1);
    check("pre_alarm_data", 32'(data), 32'h12345);
    check("pre_alarm_en", 32'(seg_en), 32'h1);

    // Alarm clears: round-robin hands back to source 2 (1 served last)
    req = 3'b110;
    step();
    check("ret_gap0", 32'(grant), 32'h0);
    check("ret_gap0_data", 32'(data), 32'h12345);
    step();
    check("ret_gap1", 32'(grant), 32'h0);
    step();
    check("ret_rr", 32'(grant), 32'h4);
    check("ret_rr_data", 32'(data), 32'h00250);

    // Owner 2 drops: two gap cycles then idle
    req = 3'b000;
    step();
    check("o2_gap0", 32'(grant), 32'h0);
    step();
    check("o2_gap1", 32'(grant), 32'h0);
    step();
    check("o2_idle", 32'(grant), 32'h0);
    check("o2_idle_en", 32'(seg_en), 32'h0);

    // Reset mid-gap after serving source 1; tie afterwards goes to source 1
    req = 3'b010;
    step();
    check("mg_owner1", 32'(grant), 32'h2);
    req = 3'b000;
    step();
    check("mg_gap", 32'(grant), 32'h0);
    sys_rst = 1'b1;
    req     = 3'b110;
    step();
    check("mg_rst_grant", 32'(grant), 32'h0);
    check("mg_rst_data", 32'(data), 32'h0);
    check("mg_rst_point", 32'(point), 32'h0);
    check("mg_rst_sign", 32'(sign), 32'h0);
    check("mg_rst_seg_en", 32'(seg_en), 32'h0);
    sys_rst = 1'b0;
    step();
    check("mg_tie_src1", 32'(grant), 32'h2);
    check("mg_tie_data", 32'(data), 32'h00777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
